mult_load_array: RTL and testbench
==================================

# mult_load_array

Parametrised multiply load array: LANES independent unsigned multipliers, each behind a LATENCY-deep register pipeline, with a per-beat selectable plain-multiply or multiply-accumulate mode. It has per-lane enables, sticky overflow flags, an XOR checksum and a beat counter. It is the scalable successor to the fixed two-multiplier wrapper in the load design, used to dial in switching load by lane count and mode.

## Interface
- WIDTH, 24: operand width per lane (A and B).
- LANES, 4: number of multiplier lanes (≥1).
- LATENCY, 3: multiplier pipeline stages (≥1).
- ACC_WIDTH, 56: accumulator and result width per lane (≥2*WIDTH).
- CLK  in  1  single clock, rising edge.
- RST_N  in  1  reset, asynchronous assert, active-low.
- IN_VALID  in  1  input beat present; no backpressure, every beat is accepted.
- MODE  in  1  0 = MULT, 1 = MAC; sampled with each beat.
- LANE_EN  in  LANES  per-lane enable; sampled with each beat.
- ACC_CLR  in  1  clear all accumulators and OVF flags.
- DATA_IN  in  LANES*2*WIDTH  lane i: A = [i*2W +: W], B = [i*2W+W +: W].
- OUT_VALID  out  1  result beat present.
- DATA_OUT  out  LANES*ACC_WIDTH  lane i result at [i*ACC_WIDTH +: ACC_WIDTH].
- CHECKSUM  out  ACC_WIDTH  XOR of all DATA_OUT lane fields, same cycle.
- OVF  out  LANES  sticky per-lane accumulator wrap flag.
- OP_COUNT  out  32  accepted IN_VALID beats, saturating at 0xFFFFFFFF.

## Operation
- Arithmetic is unsigned. Product P = A*B is 2*WIDTH bits, zero-extended to ACC_WIDTH.
- MODE and LANE_EN are tags that travel with the beat through the pipeline. MODE or enable changes between beats take effect exactly at beat boundaries; no flush is needed.
- **MULT beat:**
  - Enabled lane: DATA_OUT field = zero-extended P.
  - The accumulator is unchanged.
- **MAC beat:**
  - Enabled lane: acc ← acc + P, modulo 2^ACC_WIDTH.
  - DATA_OUT field = the new acc.
  - If the carry out of the ACC_WIDTH sum is 1, OVF[i] is set.
- **Disabled lane in a beat:**
  - Its pipeline registers do not load (no toggling).
  - Its accumulator and OVF hold.
  - Its DATA_OUT field = 0 for that beat.
- **ACC_CLR:** acts at the accumulate stage in the cycle it is asserted.
  - It zeroes every accumulator and OVF.
  - If a MAC beat reaches the accumulate stage in the same cycle, the clear is applied first, so acc = P and OVF[i] = 0.
  - ACC_CLR does not affect in-flight pipeline data.
- **Idle cycles:**
  - With IN_VALID = 0, the pipeline valid bits shift zeros.
  - DATA_OUT, CHECKSUM and OVF hold their last values.
  - OUT_VALID = 0.
- **OP_COUNT:** increments by 1 on every cycle with IN_VALID = 1, regardless of LANE_EN. It saturates at the maximum value and never wraps.

## Timing
- **Reset values:** while RST_N = 0, all of the following are 0: pipeline valid bits, stage data, accumulators, DATA_OUT, CHECKSUM, OVF, OUT_VALID and OP_COUNT.
- **Latency:** a beat with IN_VALID = 1 at edge t gives OUT_VALID = 1 with its results after edge t+LATENCY+1.
  - That is LATENCY multiply stages plus one accumulate/output register.
  - Back-to-back beats give back-to-back results at full throughput, one beat per cycle.
- **Back-to-back MAC beats on the same lane:** each beat sees the accumulator value updated by the previous beat. There is no hazard gap.
- **Reset mid-operation:** all in-flight beats are discarded. The first beat after RST_N deasserts appears LATENCY+1 cycles after it is accepted.
- CHECKSUM updates in the same cycle as DATA_OUT and from the same values.

## Test plan
All scenarios use the default parameters unless a scenario states otherwise.
- **Reset:** assert RST_N = 0 mid-stream with 3 beats in flight -> every output is 0 immediately. After release, no stale OUT_VALID ever appears.
- **MULT latency:** one beat, MODE = 0, lane 0 A = 0xFFFFFF, B = 0xFFFFFF, LANE_EN = 4'b0001 at cycle 0 -> at cycle 4:
  - OUT_VALID = 1;
  - lane 0 = 0x00FFFFFE000001;
  - lanes 1–3 = 0;
  - CHECKSUM = 0x00FFFFFE000001.
- **MAC accumulate:** 3 consecutive beats, MODE = 1, all lanes A = 2, B = 3 -> DATA_OUT lanes = 6, 12, 18 on 3 consecutive cycles. OP_COUNT = 3.
- **MAC overflow:** ACC_WIDTH = 48, two MAC beats of 0xFFFFFF × 0xFFFFFF on lane 0 ->
  - second result = 0xFFFFFC000002;
  - OVF[0] = 1 and stays 1;
  - ACC_CLR sets OVF[0] = 0.
- **Clear collision:** ACC_CLR asserted in the same cycle a MAC beat with A = 5, B = 7 reaches the accumulate stage, with acc previously 100 -> result 35.
- **Lane disable and mode mix:** alternate MODE 0/1 beats with LANE_EN = 4'b0101 -> lanes 1 and 3 output 0 and their accumulators hold. MULT beats leave lanes 0 and 2 accumulators unchanged.

Source files
------------

// File: rtl/mult_load_array.sv
// rtl/mult_load_array.sv - LANES-wide pipelined unsigned multiply / multiply-accumulate load array
module mult_load_array #(
    parameter int WIDTH     = 24,
    parameter int LANES     = 4,
    parameter int LATENCY   = 3,
    parameter int ACC_WIDTH = 56
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       in_valid_i,
    input  logic                       mode_i,
    input  logic [LANES-1:0]           lane_en_i,
    input  logic                       acc_clr_i,
    input  logic [LANES*2*WIDTH-1:0]   data_in_i,
    output logic                       out_valid_o,
    output logic [LANES*ACC_WIDTH-1:0] data_out_o,
    output logic [ACC_WIDTH-1:0]       checksum_o,
    output logic [LANES-1:0]           ovf_o,
    output logic [31:0]                op_count_o
);
    localparam int PW   = 2 * WIDTH;
    localparam int AW1  = ACC_WIDTH + 1;
    localparam int LAST = LATENCY - 1;

    logic [LATENCY-1:0]   vld_q;
    logic [LATENCY-1:0]   mode_q;
    logic [LANES-1:0]     en_q    [LATENCY];
    logic [PW-1:0]        prod_q  [LATENCY][LANES];
    logic [PW-1:0]        prod_in [LANES];

    logic [ACC_WIDTH-1:0] acc_q [LANES];
    logic [ACC_WIDTH-1:0] acc_d [LANES];
    logic [ACC_WIDTH-1:0] res_q [LANES];
    logic [ACC_WIDTH-1:0] res_d [LANES];
    logic [AW1-1:0]       sum   [LANES];
    logic [ACC_WIDTH-1:0] chk_q;
    logic [ACC_WIDTH-1:0] chk_d;
    logic [LANES-1:0]     ovf_q;
    logic [LANES-1:0]     ovf_d;
    logic                 out_valid_q;
    logic [31:0]          op_count_q;

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            prod_in[l] = PW'(data_in_i[l*2*WIDTH +: WIDTH]) * PW'(data_in_i[l*2*WIDTH+WIDTH +: WIDTH]);
        end
    end

    // Lane data registers only load when that lane's beat is live, so disabled lanes do not toggle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            vld_q  <= '0;
            mode_q <= '0;
            for (int s = 0; s < LATENCY; s++) begin
                en_q[s] <= '0;
                for (int l = 0; l < LANES; l++) begin
                    prod_q[s][l] <= '0;
                end
            end
        end else begin
            vld_q[0] <= in_valid_i;
            if (in_valid_i) begin
                mode_q[0] <= mode_i;
            end
            en_q[0] <= in_valid_i ? lane_en_i : '0;
            for (int l = 0; l < LANES; l++) begin
                if (in_valid_i && lane_en_i[l]) begin
                    prod_q[0][l] <= prod_in[l];
                end
            end
            for (int s = 1; s < LATENCY; s++) begin
                vld_q[s]  <= vld_q[s-1];
                mode_q[s] <= mode_q[s-1];
                en_q[s]   <= en_q[s-1];
                for (int l = 0; l < LANES; l++) begin
                    if (en_q[s-1][l]) begin
                        prod_q[s][l] <= prod_q[s-1][l];
                    end
                end
            end
        end
    end

    // Clear is folded in ahead of the add, so a MAC beat colliding with ACC_CLR starts from zero.
    always_comb begin
        chk_d = '0;
        for (int l = 0; l < LANES; l++) begin
            acc_d[l] = acc_clr_i ? '0 : acc_q[l];
            ovf_d[l] = acc_clr_i ? 1'b0 : ovf_q[l];
            sum[l]   = {1'b0, (acc_clr_i ? {ACC_WIDTH{1'b0}} : acc_q[l])} + AW1'(prod_q[LAST][l]);
            res_d[l] = res_q[l];
            if (vld_q[LAST]) begin
                res_d[l] = '0;
                if (en_q[LAST][l]) begin
                    if (mode_q[LAST]) begin
                        acc_d[l] = sum[l][ACC_WIDTH-1:0];
                        ovf_d[l] = ovf_d[l] | sum[l][ACC_WIDTH];
                        res_d[l] = sum[l][ACC_WIDTH-1:0];
                    end else begin
                        res_d[l] = ACC_WIDTH'(prod_q[LAST][l]);
                    end
                end
            end
            chk_d = chk_d ^ res_d[l];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            out_valid_q <= 1'b0;
            chk_q       <= '0;
            ovf_q       <= '0;
            op_count_q  <= '0;
            for (int l = 0; l < LANES; l++) begin
                acc_q[l] <= '0;
                res_q[l] <= '0;
            end
        end else begin
            out_valid_q <= vld_q[LAST];
            chk_q       <= chk_d;
            ovf_q       <= ovf_d;
            for (int l = 0; l < LANES; l++) begin
                acc_q[l] <= acc_d[l];
                res_q[l] <= res_d[l];
            end
            if (in_valid_i && (op_count_q != 32'hFFFF_FFFF)) begin
                op_count_q <= op_count_q + 32'd1;
            end
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_out
        assign data_out_o[g*ACC_WIDTH +: ACC_WIDTH] = res_q[g];
    end

    assign out_valid_o = out_valid_q;
    assign checksum_o  = chk_q;
    assign ovf_o       = ovf_q;
    assign op_count_o  = op_count_q;
endmodule

// File: tb/tb_mult_load_array.sv
// tb/tb_mult_load_array.sv - self-checking bench for mult_load_array with a beat-level reference model
module tb_mult_load_array;
    localparam int W   = 24;
    localparam int N   = 4;
    localparam int L   = 3;
    localparam int AW  = 56;
    localparam int AWS = 48;
    localparam int DW  = N * 2 * W;

    typedef struct {
        logic         vld;
        logic         mode;
        logic [N-1:0] en;
        logic [DW-1:0] din;
    } beat_t;

    typedef struct {
        logic [N-1:0]  en;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [AW-1:0] exp_lane;
        logic [AW-1:0] exp_chk;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            mode;
    logic [N-1:0]    lane_en;
    logic            acc_clr;
    logic [DW-1:0]   data_in;

    logic            out_valid;
    logic [N*AW-1:0] data_out;
    logic [AW-1:0]   checksum;
    logic [N-1:0]    ovf;
    logic [31:0]     op_count;

    logic             out_valid_s;
    logic [N*AWS-1:0] data_out_s;
    logic [AWS-1:0]   checksum_s;
    logic [N-1:0]     ovf_s;
    logic [31:0]      op_count_s;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    beat_t        hist [16];
    logic [63:0]  m_acc [N];
    logic [AW-1:0] m_out [N];
    logic         m_valid;
    logic [N-1:0] m_ovf;
    logic [31:0]  m_cnt;

    always #5 clk = ~clk;

    mult_load_array #(.WIDTH(W), .LANES(N), .LATENCY(L), .ACC_WIDTH(AW)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid), .mode_i(mode),
        .lane_en_i(lane_en), .acc_clr_i(acc_clr), .data_in_i(data_in),
        .out_valid_o(out_valid), .data_out_o(data_out), .checksum_o(checksum),
        .ovf_o(ovf), .op_count_o(op_count)
    );

    mult_load_array #(.WIDTH(W), .LANES(N), .LATENCY(L), .ACC_WIDTH(AWS)) dut_s (
        .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid), .mode_i(mode),
        .lane_en_i(lane_en), .acc_clr_i(acc_clr), .data_in_i(data_in),
        .out_valid_o(out_valid_s), .data_out_o(data_out_s), .checksum_o(checksum_s),
        .ovf_o(ovf_s), .op_count_o(op_count_s)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] pack_ab(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [DW-1:0] d;
        d = '0;
        for (int l = 0; l < N; l++) begin
            d[l*2*W +: W]   = a;
            d[l*2*W+W +: W] = b;
        end
        return d;
    endfunction

    function automatic logic [DW-1:0] rand_din();
        logic [DW-1:0] d;
        d = '0;
        for (int l = 0; l < 2*N; l++) begin
            d[l*W +: W] = ($urandom_range(0, 3) == 0) ? {W{1'b1}} : W'($urandom);
        end
        return d;
    endfunction

    function automatic logic [AW-1:0] lane_out(input int l);
        return data_out[l*AW +: AW];
    endfunction

    task automatic model_reset();
        for (int l = 0; l < N; l++) begin
            m_acc[l] = '0;
            m_out[l] = '0;
        end
        m_valid = 1'b0;
        m_ovf   = '0;
        m_cnt   = '0;
        for (int i = 0; i < 16; i++) begin
            hist[i] = '{1'b0, 1'b0, '0, '0};
        end
    endtask

    // One beat reaching the accumulate point, with this cycle's clear applied first.
    task automatic model_acc(input beat_t bt, input logic clr);
        logic [63:0] p;
        logic [63:0] s;
        logic [63:0] mask;
        mask = (64'd1 << AW) - 64'd1;
        if (clr) begin
            for (int l = 0; l < N; l++) m_acc[l] = '0;
            m_ovf = '0;
        end
        m_valid = bt.vld;
        if (bt.vld) begin
            for (int l = 0; l < N; l++) begin
                p = 64'(bt.din[l*2*W +: W]) * 64'(bt.din[l*2*W+W +: W]);
                if (!bt.en[l]) begin
                    m_out[l] = '0;
                end else if (bt.mode) begin
                    s = m_acc[l] + p;
                    if ((s >> AW) != 64'd0) m_ovf[l] = 1'b1;
                    m_acc[l] = s & mask;
                    m_out[l] = AW'(m_acc[l]);
                end else begin
                    m_out[l] = AW'(p);
                end
            end
        end
    endtask

    task automatic compare_all();
        logic [AW-1:0] chk;
        chk = '0;
        check("out_valid", out_valid, m_valid);
        for (int l = 0; l < N; l++) begin
            check($sformatf("lane%0d", l), lane_out(l), m_out[l]);
            chk = chk ^ m_out[l];
        end
        check("checksum", checksum, chk);
        check("ovf", ovf, m_ovf);
        check("op_count", op_count, m_cnt);
    endtask

    task automatic step(input logic v, input logic md, input logic [N-1:0] en,
                        input logic clr, input logic [DW-1:0] din);
        in_valid = v;
        mode     = md;
        lane_en  = en;
        acc_clr  = clr;
        data_in  = din;
        model_acc(hist[(cyc + 16 - L) % 16], clr);
        hist[cyc % 16] = '{v, md, en, din};
        if (v && (m_cnt != 32'hFFFF_FFFF)) m_cnt = m_cnt + 32'd1;
        @(posedge clk);
        #1;
        cyc++;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        mode     = 1'b0;
        lane_en  = '0;
        acc_clr  = 1'b0;
        data_in  = '0;
        #1;
        check("rst out_valid", out_valid, 0);
        for (int l = 0; l < N; l++) check($sformatf("rst lane%0d", l), lane_out(l), 0);
        check("rst checksum", checksum, 0);
        check("rst ovf", ovf, 0);
        check("rst op_count", op_count, 0);
        check("rst small out_valid", out_valid_s, 0);
        check("rst small ovf", ovf_s, 0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
    endtask

    vec_t vecs [5];

    initial begin
        vecs[0] = '{4'b0001, 24'hFFFFFF, 24'hFFFFFF, 56'h00FFFFFE000001, 56'h00FFFFFE000001};
        vecs[1] = '{4'b1111, 24'd2,      24'd3,      56'd6,              56'd0};
        vecs[2] = '{4'b0111, 24'h1000,   24'h1000,   56'h1000000,        56'h1000000};
        vecs[3] = '{4'b0000, 24'd5,      24'd5,      56'd0,              56'd0};
        vecs[4] = '{4'b1000, 24'h123,    24'h10,     56'h1230,           56'h1230};

        rst_n    = 1'b0;
        in_valid = 1'b0;
        mode     = 1'b0;
        lane_en  = '0;
        acc_clr  = 1'b0;
        data_in  = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // MAC accumulate: 6, 12, 18 on consecutive cycles
        repeat (3) step(1'b1, 1'b1, 4'hF, 1'b0, pack_ab(24'd2, 24'd3));
        for (int i = 0; i < 3; i++) begin
            idle(1);
            check("mac valid", out_valid, 1);
            for (int l = 0; l < N; l++) check($sformatf("mac lane%0d", l), lane_out(l), 6 * (i + 1));
        end
        check("mac op_count", op_count, 3);

        // Single MULT beats from the table, including latency
        for (int v = 0; v < 5; v++) begin
            step(1'b1, 1'b0, vecs[v].en, 1'b0, pack_ab(vecs[v].a, vecs[v].b));
            for (int i = 0; i < L; i++) begin
                idle(1);
                if (i == L - 2) check($sformatf("vec%0d early valid", v), out_valid, 0);
            end
            check($sformatf("vec%0d valid", v), out_valid, 1);
            for (int l = 0; l < N; l++)
                check($sformatf("vec%0d lane%0d", v, l), lane_out(l), vecs[v].en[l] ? vecs[v].exp_lane : 56'd0);
            check($sformatf("vec%0d checksum", v), checksum, vecs[v].exp_chk);
        end

        // Clear collides with a MAC beat at the accumulate stage
        step(1'b0, 1'b0, '0, 1'b1, '0);
        step(1'b1, 1'b1, 4'b0001, 1'b0, pack_ab(24'd10, 24'd10));
        step(1'b1, 1'b1, 4'b0001, 1'b0, pack_ab(24'd5, 24'd7));
        idle(L - 1);
        check("collide pre acc", lane_out(0), 100);
        step(1'b0, 1'b0, '0, 1'b1, '0);
        check("collide result", lane_out(0), 35);

        // Overflow on the 48-bit accumulator instance
        step(1'b0, 1'b0, '0, 1'b1, '0);
        repeat (2) step(1'b1, 1'b1, 4'b0001, 1'b0, pack_ab(24'hFFFFFF, 24'hFFFFFF));
        idle(L);
        check("ovf48 result", data_out_s[0 +: AWS], 48'hFFFFFC000002);
        check("ovf48 flag", ovf_s[0], 1);
        idle(4);
        check("ovf48 sticky", ovf_s[0], 1);
        step(1'b0, 1'b0, '0, 1'b1, '0);
        check("ovf48 cleared", ovf_s[0], 0);

        // Lane disable with mode mix
        step(1'b0, 1'b0, '0, 1'b1, '0);
        step(1'b1, 1'b1, 4'hF, 1'b0, pack_ab(24'd1, 24'd1));
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'(i % 2), 4'b0101, 1'b0, (i % 2) ? pack_ab(24'd2, 24'd2) : pack_ab(24'd3, 24'd3));
        step(1'b1, 1'b1, 4'hF, 1'b0, pack_ab(24'd1, 24'd1));
        idle(L);
        check("mix lane0", lane_out(0), 10);
        check("mix lane1", lane_out(1), 2);
        check("mix lane2", lane_out(2), 10);
        check("mix lane3", lane_out(3), 2);

        // Reset with three beats in flight
        repeat (3) step(1'b1, 1'b0, 4'hF, 1'b0, rand_din());
        do_reset();
        idle(L + 2);
        step(1'b1, 1'b0, 4'hF, 1'b0, pack_ab(24'd7, 24'd9));
        idle(L);
        check("post-reset valid", out_valid, 1);
        check("post-reset lane0", lane_out(0), 63);

        // Randomized traffic against the model
        repeat (400)
            step($urandom_range(0, 3) != 0, 1'($urandom), N'($urandom),
                 $urandom_range(0, 15) == 0, rand_din());
        idle(L + 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
